// File: rtl/if_buffer_pkg.sv
// Shared widths, constants and the fetch-entry payload for the instruction fetch buffer.
package if_buffer_pkg;

    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned RegBus      = 32;
    localparam int unsigned ExcBus      = 2;

    localparam logic [RegBus-1:0] ZeroWord    = 32'h0000_0000;
    localparam logic              InstInvalid = 1'b0;
    // Level of rst that holds the block in reset (active-low)
    localparam logic              RstEnable   = 1'b0;

    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [RegBus-1:0]      inst;
        logic [ExcBus-1:0]      excepttype;
    } fetch_entry_t;

    localparam int unsigned EntryW = $bits(fetch_entry_t);

endpackage

// File: rtl/if_buffer_sync_fifo_reg.sv
// Register-file circular FIFO; occupancy counter decides full/empty, clr empties it.
module sync_fifo_reg
    import if_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [PTR_W:0]   cnt,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wp;
    logic [PTR_W-1:0] r_rp;
    logic [PTR_W:0]   r_cnt;
    logic             w_push;
    logic             w_pop;

    // Guard push/pop against full/empty; clr overrides both
    assign w_push = push && !full && !clr;
    assign w_pop  = pop && !empty && !clr;

    // Pointer and occupancy update; power-of-two depth makes pointer wrap natural
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (clr) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + PTR_W'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + (PTR_W+1)'(1);
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - (PTR_W+1)'(1);
            end
        end
    end

    // Entry storage, cleared on reset only
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wp] <= din;
        end
    end

    assign dout  = r_mem[r_rp];
    assign cnt   = r_cnt;
    assign full  = (r_cnt == (PTR_W+1)'(DEPTH));
    assign empty = (r_cnt == '0);

endmodule

// File: rtl/if_buffer.sv
// Instruction fetch buffer: decouples fetch from decode stalls, flushable, zero head when empty.
module if_buffer
    import if_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   stall,
    input  logic                   if_valid,
    input  logic [InstAddrBus-1:0] if_pc,
    input  logic [RegBus-1:0]      if_inst,
    input  logic [ExcBus-1:0]      if_excepttype,
    output logic                   if_ready,
    output logic                   id_inst_valid,
    output logic [InstAddrBus-1:0] id_inst_pc,
    output logic [RegBus-1:0]      id_inst,
    output logic [ExcBus-1:0]      id_excepttype,
    output logic [PTR_W:0]         count
);

    fetch_entry_t w_wr_entry;
    fetch_entry_t w_head;
    logic         w_full;
    logic         w_empty;
    logic         w_push;
    logic         w_pop;

    // Pack the fetch fields; push/pop qualified here so ready never sees stall
    assign w_wr_entry = '{pc: if_pc, inst: if_inst, excepttype: if_excepttype};
    assign w_push     = if_valid && !w_full && !flush;
    assign w_pop      = !w_empty && !stall && !flush;

    sync_fifo_reg #(
        .WIDTH (EntryW),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_wr_entry),
        .dout  (w_head),
        .cnt   (count),
        .full  (w_full),
        .empty (w_empty)
    );

    // Head presented to decode, forced to zero while the buffer is empty
    always_comb begin
        id_inst_valid = InstInvalid;
        id_inst_pc    = ZeroWord;
        id_inst       = ZeroWord;
        id_excepttype = '0;
        if (!w_empty) begin
            id_inst_valid = 1'b1;
            id_inst_pc    = w_head.pc;
            id_inst       = w_head.inst;
            id_excepttype = w_head.excepttype;
        end
    end

    assign if_ready = !w_full;

endmodule

// File: tb/tb_if_buffer.sv
// Directed self-checking bench for if_buffer (DEPTH = 4).
module tb_if_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [1:0]  if_excepttype;
    logic        if_ready;
    logic        id_inst_valid;
    logic [31:0] id_inst_pc;
    logic [31:0] id_inst;
    logic [1:0]  id_excepttype;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    if_buffer #(.DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .stall         (stall),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_excepttype (if_excepttype),
        .if_ready      (if_ready),
        .id_inst_valid (id_inst_valid),
        .id_inst_pc    (id_inst_pc),
        .id_inst       (id_inst),
        .id_excepttype (id_excepttype),
        .count         (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_only(input logic [31:0] pc);
        if_valid = 1'b1;
        if_pc    = pc;
        if_inst  = pc ^ 32'h0280_0000;
        tick();
        if_valid = 1'b0;
    endtask

    localparam logic [31:0] Base = 32'h1c00_0000;

    initial begin
        rst = 1'b0; flush = 1'b0; stall = 1'b0; if_valid = 1'b0;
        if_pc = '0; if_inst = '0; if_excepttype = '0;
        #12;
        check("rst_ready", 64'(if_ready), 64'(1));
        check("rst_valid", 64'(id_inst_valid), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst_pc", 64'(id_inst_pc), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Single push, visible next cycle, then popped
        if_valid = 1'b1; if_pc = Base; if_inst = 32'h0280_0c0c; if_excepttype = 2'd0;
        tick();
        if_valid = 1'b0;
        check("single_valid", 64'(id_inst_valid), 64'(1));
        check("single_pc", 64'(id_inst_pc), 64'(32'h1c00_0000));
        check("single_inst", 64'(id_inst), 64'(32'h0280_0c0c));
        check("single_exc", 64'(id_excepttype), 64'(0));
        check("single_count", 64'(count), 64'(1));
        tick();
        check("pop_count", 64'(count), 64'(0));
        check("pop_valid", 64'(id_inst_valid), 64'(0));
        check("pop_inst", 64'(id_inst), 64'(0));

        // Stall held, five pushes, fifth refused
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("stall_ready", 64'(if_ready), 64'(k < 4));
            push_only(Base + 32'(4 * k));
        end
        check("full_count", 64'(count), 64'(4));
        check("full_ready", 64'(if_ready), 64'(0));
        stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("drain_valid", 64'(id_inst_valid), 64'(1));
            check("drain_pc", 64'(id_inst_pc), 64'(Base + 32'(4 * k)));
            tick();
        end
        check("drain_empty", 64'(id_inst_valid), 64'(0));

        // Continuous push and pop: occupancy steady at 1, pointers wrap
        for (int i = 0; i < 11; i++) begin
            if (i > 0) begin
                check("stream_count", 64'(count), 64'(1));
                check("stream_pc", 64'(id_inst_pc), 64'(32'h1c00_1000 + 32'(4 * (i - 1))));
            end
            if_valid = 1'b1;
            if_pc    = 32'h1c00_1000 + 32'(4 * i);
            tick();
        end
        if_valid = 1'b0;
        check("stream_last", 64'(id_inst_pc), 64'(32'h1c00_1028));
        tick();
        check("stream_end", 64'(count), 64'(0));

        // Flush with three entries and a concurrent fetch
        stall = 1'b1;
        for (int k = 0; k < 3; k++) push_only(32'h1c00_2000 + 32'(4 * k));
        check("preflush_count", 64'(count), 64'(3));
        flush = 1'b1; if_valid = 1'b1; if_pc = 32'hdead_beef;
        tick();
        flush = 1'b0; if_valid = 1'b0;
        check("flush_count", 64'(count), 64'(0));
        check("flush_valid", 64'(id_inst_valid), 64'(0));
        check("flush_ready", 64'(if_ready), 64'(1));
        push_only(32'h1c00_3000);
        check("postflush_pc", 64'(id_inst_pc), 64'(32'h1c00_3000));
        check("postflush_count", 64'(count), 64'(1));
        stall = 1'b0;
        tick();
        check("postflush_empty", 64'(count), 64'(0));

        // Full buffer: pop happens, same-cycle push refused
        stall = 1'b1;
        for (int k = 0; k < 4; k++) push_only(32'h1c00_4000 + 32'(4 * k));
        stall = 1'b0; if_valid = 1'b1; if_pc = 32'h1c00_5000;
        tick();
        if_valid = 1'b0;
        check("fullpop_count", 64'(count), 64'(3));
        check("fullpop_ready", 64'(if_ready), 64'(1));
        for (int k = 1; k < 4; k++) begin
            check("fullpop_pc", 64'(id_inst_pc), 64'(32'h1c00_4000 + 32'(4 * k)));
            tick();
        end
        check("fullpop_dropped", 64'(id_inst_valid), 64'(0));

        // Asynchronous reset mid-cycle with two entries
        stall = 1'b1;
        push_only(32'h1c00_6000);
        push_only(32'h1c00_6004);
        check("prerst_count", 64'(count), 64'(2));
        #2;
        rst = 1'b0;
        #1;
        check("arst_count", 64'(count), 64'(0));
        check("arst_valid", 64'(id_inst_valid), 64'(0));
        check("arst_pc", 64'(id_inst_pc), 64'(0));
        check("arst_ready", 64'(if_ready), 64'(1));
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("after_rst_count", 64'(count), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
